nios_system_4a_cpu_cpu_ocimem_ctrl: RTL

System-clock debug memory controller sitting directly downstream of the CPU debug-slave wrapper. It consumes the synchronised JTAG data word and the one-cycle `take_action_ocimem_*` strobes, and performs word reads and writes on a local on-chip monitor RAM. It returns read data, ready and error status (`MonDReg`, `monitor_ready`, `monitor_error`) to the debug slave for shift-out.

---
 rtl/nios_system_4a_cpu_cpu_ocimem_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nios_system_4a_cpu_cpu_ocimem_ctrl.sv
// Debug memory controller for the on-chip monitor RAM.
// Decodes the one-cycle debug-slave strobes into word reads and writes,
// returning data, ready and a sticky error flag. Reads take two cycles
// (address presentation, then capture of the registered RAM output).
module nios_system_4a_cpu_cpu_ocimem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    output logic [31:0]           MonDReg,
    output logic [ADDR_WIDTH-1:0] MonAReg,
    output logic                  monitor_ready,
    output logic                  monitor_error,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_ADDR = 2'd1;
    localparam logic [1:0] ST_RD_CAPT = 2'd2;

    // One extra bit so a full-depth RAM (MEM_WORDS == 2^ADDR_WIDTH) compares correctly.
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_WORDS - 1);

    logic [1:0]            state_reg, state_next;
    logic [31:0]           mon_d_reg, mon_d_next;
    logic [ADDR_WIDTH-1:0] mon_a_reg, mon_a_next;
    logic                  ready_reg, ready_next;
    logic                  error_reg, error_next;
    logic                  autoinc_reg, autoinc_next;
    logic [31:0]           ram_rdata_reg;
    logic [31:0]           ram_mem [MEM_WORDS];

    logic [7:0]            jdo_addr_field;
    logic [ADDR_WIDTH-1:0] jdo_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  in_range;
    logic                  any_strobe;
    logic                  multi_strobe;
    logic                  ram_we;
    logic                  ram_re;
    logic                  err_set;
    logic                  err_clr;

    assign jdo_addr_field = jdo[33:26];
    assign jdo_addr       = ADDR_WIDTH'(jdo_addr_field);
    assign addr_inc       = (mon_a_reg == LAST_ADDR) ? '0 : mon_a_reg + ADDR_WIDTH'(1);
    assign in_range       = ({1'b0, mon_a_reg} < MEM_LIMIT);
    assign any_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign multi_strobe   = (take_action_ocimem_a & take_no_action_ocimem_a)
                          | (take_action_ocimem_a & take_action_ocimem_b)
                          | (take_no_action_ocimem_a & take_action_ocimem_b);
    // MonAReg is frozen while busy, so it is still the read address in RD_ADDR.
    assign ram_re         = (state_reg == ST_RD_ADDR) && in_range;

    // Strobe decode, read sequencing and error bookkeeping.
    always_comb begin
        state_next   = state_reg;
        mon_d_next   = mon_d_reg;
        mon_a_next   = mon_a_reg;
        ready_next   = ready_reg;
        autoinc_next = autoinc_reg;
        ram_we       = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (multi_strobe) begin
                    err_set = 1'b1;
                end
                if (take_action_ocimem_a) begin
                    mon_a_next   = jdo_addr;
                    autoinc_next = jdo[24];
                    ready_next   = 1'b0;
                    err_clr      = jdo[23];
                    if (jdo[25]) begin
                        state_next = ST_RD_ADDR;
                    end
                end else if (take_no_action_ocimem_a) begin
                    if (autoinc_reg) begin
                        mon_a_next = addr_inc;
                    end
                    ready_next = 1'b0;
                    state_next = ST_RD_ADDR;
                end else if (take_action_ocimem_b) begin
                    mon_d_next = jdo[34:3];
                    ready_next = 1'b1;
                    if (in_range) begin
                        ram_we = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    if (autoinc_reg) begin
                        mon_a_next = addr_inc;
                    end
                end
            end
            ST_RD_ADDR: begin
                err_set    = any_strobe;
                state_next = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                err_set    = any_strobe;
                ready_next = 1'b1;
                state_next = ST_IDLE;
                if (in_range) begin
                    mon_d_next = ram_rdata_reg;
                end else begin
                    mon_d_next = '0;
                    err_set    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // A clear and a set on the same edge resolve to set.
        error_next = (error_reg & ~err_clr) | err_set;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            mon_d_reg   <= '0;
            mon_a_reg   <= '0;
            ready_reg   <= 1'b0;
            error_reg   <= 1'b0;
            autoinc_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mon_d_reg   <= mon_d_next;
            mon_a_reg   <= mon_a_next;
            ready_reg   <= ready_next;
            error_reg   <= error_next;
            autoinc_reg <= autoinc_next;
        end
    end

    // Monitor RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[mon_a_reg] <= jdo[34:3];
        end
    end

    // Registered RAM read port, loaded during RD_ADDR.
    always_ff @(posedge clk) begin
        if (ram_re) begin
            ram_rdata_reg <= ram_mem[mon_a_reg];
        end
    end

    assign MonDReg       = mon_d_reg;
    assign MonAReg       = mon_a_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule
